// File: rtl/keypad_pkg.sv
// Shared types, keymap and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [3:0] ROW_INIT = 4'b1110;

    // Indexed {row_idx, col_idx}; E and F stand for '*' and '#'.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] zero_index(input logic [3:0] v);
        zero_index = 2'd0;
        for (int unsigned i = 0; i < 4; i++)
            if (!v[i]) zero_index = 2'(i);
    endfunction

    function automatic logic single_zero(input logic [3:0] v);
        return $countones(v) == 3;
    endfunction

    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

endpackage

// File: rtl/keypad_debounce_ctr.sv
// Scan tick generator and saturating debounce match counter.
module keypad_debounce_ctr #(
    parameter int unsigned SCAN_TICKS   = 100_000,
    parameter int unsigned DEBOUNCE_CNT = 10
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic cnt_clr,
    input  logic cnt_load1,
    input  logic cnt_inc,
    output logic tick,
    output logic cnt_next_hit
);

    localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_PRE   = CW'(DEBOUNCE_CNT - 1);

    logic [TW-1:0] tick_cnt;
    logic [CW-1:0] count;

    assign tick         = (tick_cnt == TICK_LAST);
    // True when one more increment reaches the acceptance threshold.
    assign cnt_next_hit = (count >= CNT_PRE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                          count <= '0;
        else if (cnt_clr)                    count <= '0;
        else if (cnt_load1)                  count <= CW'(1);
        else if (cnt_inc && count != CNT_MAX) count <= count + CW'(1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, debounce, single pulse per press, 32-bit entry shift register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned SCAN_MS      = 1,
    parameter int unsigned DEBOUNCE_CNT = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] data
);

    localparam int unsigned SCAN_TICKS = CLK_FREQ / 1000 * SCAN_MS;

    state_t     state, state_n;
    logic [3:0] row_n, cap, cap_n, col_m, col_s, accept_code;
    logic       tick, cnt_next_hit, cnt_clr, cnt_load1, cnt_inc, accept;

    keypad_debounce_ctr #(
        .SCAN_TICKS   (SCAN_TICKS),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_ctr (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cnt_clr      (cnt_clr),
        .cnt_load1    (cnt_load1),
        .cnt_inc      (cnt_inc),
        .tick         (tick),
        .cnt_next_hit (cnt_next_hit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= SCAN;
            row   <= ROW_INIT;
            cap   <= '1;
        end else begin
            state <= state_n;
            row   <= row_n;
            cap   <= cap_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        cap_n     = cap;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        accept    = 1'b0;
        case (state)
            SCAN: if (tick) begin
                if (col_s == '1) begin
                    row_n = rotate_row(row);
                end else begin
                    cap_n     = col_s;
                    cnt_load1 = 1'b1;
                    // With a threshold of one the entry sample is already the accepting one.
                    if (DEBOUNCE_CNT == 1) begin
                        if (single_zero(col_s)) begin
                            state_n = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_n = RELEASE;
                            cnt_clr = 1'b1;
                        end
                    end else begin
                        state_n = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: if (tick) begin
                if (col_s == cap) begin
                    cnt_inc = 1'b1;
                    if (cnt_next_hit) begin
                        cnt_clr = 1'b1;
                        if (single_zero(cap)) begin
                            state_n = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_n = RELEASE;
                        end
                    end
                end else begin
                    state_n = SCAN;
                    row_n   = rotate_row(row);
                    cnt_clr = 1'b1;
                end
            end
            PRESSED: begin
                state_n = RELEASE;
                cnt_clr = 1'b1;
            end
            RELEASE: if (tick) begin
                if (col_s == '1) begin
                    cnt_inc = 1'b1;
                    if (cnt_next_hit) begin
                        state_n = SCAN;
                        row_n   = rotate_row(row);
                        cnt_clr = 1'b1;
                    end
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    assign accept_code = KEYMAP[{zero_index(row), zero_index(cap_n)}];

    // Outputs are loaded on the accepting edge so code and data are valid alongside the pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            data      <= '0;
        end else begin
            key_valid <= accept;
            if (accept) key_code <= accept_code;
            if (clr)         data <= '0;
            else if (accept) data <= {data[27:0], accept_code};
        end
    end

endmodule
